// File: rtl/fetch_unit_pkg.sv
// Shared widths, constants and FSM encoding for the fetch stage of the
// two-accumulator 8-bit core.
package fetch_unit_pkg;

  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetchState_t;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: synchronous reset, absolute load and wrapping increment.
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] loadValue,
  input  logic              incr,
  output logic [ADDR_W-1:0] pc
);

  // A load always beats an increment so a redirect never advances past its target.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= loadValue;
    end else if (incr) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, handshakes with the instruction ROM and
// squashes the in-flight instruction when the decoder redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iBranch_taken,
  input  logic               iJumpTaken,
  input  logic [ADDR_W-1:0]  iBranch_dir,
  input  logic               iStall,
  input  logic [INSTR_W-1:0] iMem_data,
  input  logic               iMem_ready,
  output logic               oMem_req,
  output logic [ADDR_W-1:0]  oMem_addr,
  output logic [INSTR_W-1:0] oInstruction,
  output logic               oInstr_valid,
  output logic [ADDR_W-1:0]  oPC
);

  fetchState_t       state;
  fetchState_t       nextState;
  logic [ADDR_W-1:0] pc;
  logic              redirect;
  logic              takeRedirect;
  logic              fetchDone;

  assign redirect     = iBranch_taken | iJumpTaken;
  assign takeRedirect = redirect && (state != S_RESET);
  assign fetchDone    = (state == S_FETCH) && iMem_ready && !redirect;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) uPcReg (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (takeRedirect),
    .loadValue(iBranch_dir),
    .incr     (fetchDone),
    .pc       (pc)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_RESET;
    end else begin
      state <= nextState;
    end
  end

  // Redirect outranks both the ROM handshake and a downstream stall.
  always_comb begin
    nextState = state;
    case (state)
      S_RESET: nextState = S_FETCH;
      S_FETCH: begin
        if (redirect) begin
          nextState = S_FETCH;
        end else if (iMem_ready) begin
          nextState = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect || !iStall) begin
          nextState = S_FETCH;
        end
      end
      default: nextState = S_RESET;
    endcase
  end

  always_comb begin
    oMem_req  = (state == S_FETCH);
    oMem_addr = pc;
  end

  // Issued instruction stays up only while held in S_HOLD; otherwise decoder sees a NOP.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      oInstruction <= NOP_INSTR;
      oInstr_valid <= 1'b0;
      oPC          <= RESET_PC;
    end else if (takeRedirect) begin
      oInstruction <= NOP_INSTR;
      oInstr_valid <= 1'b0;
    end else if (fetchDone) begin
      oInstruction <= iMem_data;
      oInstr_valid <= 1'b1;
      oPC          <= pc;
    end else if ((state == S_HOLD) && !iStall) begin
      oInstruction <= NOP_INSTR;
      oInstr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a vector table for the main fetch flow plus
// hand-written sequences for wrap, stall/squash and mid-fetch reset.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic               Clock;
  logic               Reset;
  logic               iBranch_taken;
  logic               iJumpTaken;
  logic [ADDR_W-1:0]  iBranch_dir;
  logic               iStall;
  logic [INSTR_W-1:0] iMem_data;
  logic               iMem_ready;
  logic               oMem_req;
  logic [ADDR_W-1:0]  oMem_addr;
  logic [INSTR_W-1:0] oInstruction;
  logic               oInstr_valid;
  logic [ADDR_W-1:0]  oPC;

  int passCount = 0;
  int checkCount = 0;

  typedef struct {
    logic               rst;
    logic               br;
    logic               jmp;
    logic [ADDR_W-1:0]  dir;
    logic               stall;
    logic               rdy;
    logic [INSTR_W-1:0] data;
    logic               expReq;
    logic [ADDR_W-1:0]  expAddr;
    logic [INSTR_W-1:0] expInstr;
    logic               expValid;
    logic [ADDR_W-1:0]  expPc;
  } vector_t;

  vector_t vecs[23];

  fetch_unit dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iBranch_taken(iBranch_taken),
    .iJumpTaken   (iJumpTaken),
    .iBranch_dir  (iBranch_dir),
    .iStall       (iStall),
    .iMem_data    (iMem_data),
    .iMem_ready   (iMem_ready),
    .oMem_req     (oMem_req),
    .oMem_addr    (oMem_addr),
    .oInstruction (oInstruction),
    .oInstr_valid (oInstr_valid),
    .oPC          (oPC)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Drive one cycle of inputs, then settle just past the rising edge.
  task automatic applyStimulus(input logic rst, input logic br, input logic jmp,
                               input logic [ADDR_W-1:0] dir, input logic stall,
                               input logic rdy, input logic [INSTR_W-1:0] data);
    Reset         = rst;
    iBranch_taken = br;
    iJumpTaken    = jmp;
    iBranch_dir   = dir;
    iStall        = stall;
    iMem_ready    = rdy;
    iMem_data     = data;
    @(posedge Clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic req,
                             input logic [ADDR_W-1:0] addr,
                             input logic [INSTR_W-1:0] instr, input logic valid,
                             input logic [ADDR_W-1:0] pcExp);
    checkCount++;
    if (oMem_req === req && oMem_addr === addr && oInstruction === instr &&
        oInstr_valid === valid && oPC === pcExp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got req=%b addr=%0d instr=%h valid=%b pc=%0d, expected req=%b addr=%0d instr=%h valid=%b pc=%0d",
               name, oMem_req, oMem_addr, oInstruction, oInstr_valid, oPC,
               req, addr, instr, valid, pcExp);
    end
  endtask

  initial begin
    Reset = 1'b1; iBranch_taken = 1'b0; iJumpTaken = 1'b0; iBranch_dir = '0;
    iStall = 1'b0; iMem_ready = 1'b0; iMem_data = '0;

    // rst br jmp dir stall rdy data | req addr instr valid pc
    vecs[0]  = '{1, 0, 0, 10'd0,   0, 0, 16'h0000, 0, 10'd0,   16'h0000, 0, 10'd0};
    vecs[1]  = '{0, 0, 0, 10'd0,   0, 0, 16'h0000, 1, 10'd0,   16'h0000, 0, 10'd0};
    vecs[2]  = '{0, 0, 0, 10'd0,   0, 1, 16'h1000, 0, 10'd1,   16'h1000, 1, 10'd0};
    vecs[3]  = '{0, 0, 0, 10'd0,   0, 0, 16'h0000, 1, 10'd1,   16'h0000, 0, 10'd0};
    vecs[4]  = '{0, 0, 0, 10'd0,   0, 1, 16'h1001, 0, 10'd2,   16'h1001, 1, 10'd1};
    vecs[5]  = '{0, 0, 0, 10'd0,   0, 0, 16'h0000, 1, 10'd2,   16'h0000, 0, 10'd1};
    vecs[6]  = '{0, 0, 0, 10'd0,   0, 1, 16'h1002, 0, 10'd3,   16'h1002, 1, 10'd2};
    vecs[7]  = '{0, 0, 0, 10'd0,   0, 0, 16'h0000, 1, 10'd3,   16'h0000, 0, 10'd2};
    vecs[8]  = '{0, 0, 0, 10'd0,   0, 1, 16'h1003, 0, 10'd4,   16'h1003, 1, 10'd3};
    vecs[9]  = '{0, 0, 0, 10'd0,   0, 0, 16'h0000, 1, 10'd4,   16'h0000, 0, 10'd3};
    vecs[10] = '{0, 0, 0, 10'd0,   0, 1, 16'h1004, 0, 10'd5,   16'h1004, 1, 10'd4};
    vecs[11] = '{0, 0, 0, 10'd0,   0, 0, 16'h0000, 1, 10'd5,   16'h0000, 0, 10'd4};
    vecs[12] = '{0, 0, 0, 10'd0,   0, 0, 16'hDEAD, 1, 10'd5,   16'h0000, 0, 10'd4};
    vecs[13] = '{0, 0, 0, 10'd0,   0, 0, 16'hDEAD, 1, 10'd5,   16'h0000, 0, 10'd4};
    vecs[14] = '{0, 0, 0, 10'd0,   0, 1, 16'h1005, 0, 10'd6,   16'h1005, 1, 10'd5};
    vecs[15] = '{0, 0, 0, 10'd0,   0, 0, 16'h0000, 1, 10'd6,   16'h0000, 0, 10'd5};
    vecs[16] = '{0, 0, 0, 10'd0,   0, 1, 16'h1006, 0, 10'd7,   16'h1006, 1, 10'd6};
    vecs[17] = '{0, 0, 0, 10'd0,   0, 0, 16'h0000, 1, 10'd7,   16'h0000, 0, 10'd6};
    vecs[18] = '{0, 0, 1, 10'd300, 0, 1, 16'h1007, 1, 10'd300, 16'h0000, 0, 10'd6};
    vecs[19] = '{0, 0, 0, 10'd0,   0, 1, 16'h112C, 0, 10'd301, 16'h112C, 1, 10'd300};
    vecs[20] = '{0, 1, 0, 10'd50,  0, 0, 16'h0000, 1, 10'd50,  16'h0000, 0, 10'd300};
    vecs[21] = '{0, 1, 0, 10'd60,  0, 1, 16'h9999, 1, 10'd60,  16'h0000, 0, 10'd300};
    vecs[22] = '{0, 0, 0, 10'd0,   0, 1, 16'h103C, 0, 10'd61,  16'h103C, 1, 10'd60};

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].br, vecs[i].jmp, vecs[i].dir,
                    vecs[i].stall, vecs[i].rdy, vecs[i].data);
      checkOutput($sformatf("vec%0d", i), vecs[i].expReq, vecs[i].expAddr,
                  vecs[i].expInstr, vecs[i].expValid, vecs[i].expPc);
    end

    // PC wrap: fetch at 1023 issues with oPC=1023 and the next request goes to 0.
    applyStimulus(0, 0, 1, 10'd1023, 0, 0, 16'h0000);
    checkOutput("wrapJump", 1, 10'd1023, 16'h0000, 0, 10'd60);
    applyStimulus(0, 0, 0, 10'd0, 0, 1, 16'h13FF);
    checkOutput("wrapIssue", 0, 10'd0, 16'h13FF, 1, 10'd1023);
    applyStimulus(0, 0, 0, 10'd0, 0, 0, 16'h0000);
    checkOutput("wrapNextReq", 1, 10'd0, 16'h0000, 0, 10'd1023);

    // Stall holds the issued word, then a branch squashes it anyway.
    applyStimulus(0, 0, 0, 10'd0, 0, 1, 16'h1000);
    checkOutput("stallIssue", 0, 10'd1, 16'h1000, 1, 10'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 10'd0, 1, 0, 16'h0000);
      checkOutput($sformatf("stallHold%0d", i), 0, 10'd1, 16'h1000, 1, 10'd0);
    end
    applyStimulus(0, 1, 0, 10'd64, 1, 0, 16'h0000);
    checkOutput("stallSquash", 1, 10'd64, 16'h0000, 0, 10'd0);
    applyStimulus(0, 0, 0, 10'd0, 0, 1, 16'h1040);
    checkOutput("afterSquash", 0, 10'd65, 16'h1040, 1, 10'd64);

    // Reset mid-fetch with ready high: ROM data ignored, one idle cycle, restart at 0.
    applyStimulus(0, 0, 0, 10'd0, 0, 0, 16'h0000);
    checkOutput("preResetFetch", 1, 10'd65, 16'h0000, 0, 10'd64);
    applyStimulus(1, 0, 0, 10'd0, 0, 1, 16'hBEEF);
    checkOutput("midFetchReset", 0, 10'd0, 16'h0000, 0, 10'd0);
    applyStimulus(0, 0, 0, 10'd0, 0, 1, 16'hBEEF);
    checkOutput("resetIdleIgnoresRdy", 1, 10'd0, 16'h0000, 0, 10'd0);
    applyStimulus(0, 0, 0, 10'd0, 0, 1, 16'h1000);
    checkOutput("restartFetch", 0, 10'd1, 16'h1000, 1, 10'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage for the two-accumulator 8-bit core. It is the other end of the decoder interface: it drives the 16-bit instruction word into the decoder and consumes the decoder's branch/jump redirect outputs.
- Owns the 10-bit program counter and the request/ready handshake to the instruction ROM.
- Squashes the in-flight instruction on a redirect.

Parameters:
- ADDR_W, 10, program counter / ROM address width
- INSTR_W, 16, instruction word width
- RESET_PC, 10'd0, PC value loaded on reset
- NOP_INSTR, 16'h0000, word issued while no valid instruction is available (decodes as all-zero controls)

Ports:
- Clock  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- iBranch_taken  in  1  registered branch-taken from decoder
- iJumpTaken  in  1  registered jump-taken from decoder
- iBranch_dir  in  ADDR_W  absolute redirect target from decoder; branches arrive zero-extended from 7 bits
- iStall  in  1  downstream cannot accept a new instruction this cycle
- iMem_data  in  INSTR_W  ROM read data, valid when iMem_ready=1
- iMem_ready  in  1  ROM completes the current request
- oMem_req  out  1  fetch request to ROM
- oMem_addr  out  ADDR_W  fetch address (equals PC)
- oInstruction  out  INSTR_W  instruction word to decoder
- oInstr_valid  out  1  oInstruction is a real fetched instruction
- oPC  out  ADDR_W  address of the instruction currently on oInstruction

Behaviour:
- Reset (Clock edge with Reset=1):
  - PC=RESET_PC, state=S_RESET.
  - oMem_req=0, oInstruction=NOP_INSTR, oInstr_valid=0, oPC=RESET_PC.
  - Reset overrides every other input, including mid-fetch. Any outstanding ROM request is abandoned, and ready/data arriving in the reset cycle is ignored.
- Redirect = iBranch_taken | iJumpTaken.
  - Redirect has priority over stall and over ROM ready.
- FSM states: S_RESET, S_FETCH, S_HOLD.
- S_RESET:
  - Next cycle goes to S_FETCH; oMem_req rises.
  - Minimum one cycle with oMem_req=0 after Reset deasserts.
- S_FETCH:
  - oMem_req=1 and oMem_addr=PC, held stable until iMem_ready=1.
  - On iMem_ready=1 with no redirect: oInstruction<=iMem_data, oInstr_valid<=1, oPC<=PC, PC<=PC+1 (mod 2^ADDR_W, so 1023 wraps to 0), state<=S_HOLD.
  - While waiting: oInstruction=NOP_INSTR, oInstr_valid=0.
- S_HOLD:
  - If iStall=1: oInstruction, oInstr_valid and oPC are held and oMem_req=0.
  - If iStall=0: go to S_FETCH and present a new request next cycle. oInstruction returns to NOP_INSTR/valid=0 until the next ready.
  - Throughput is therefore one instruction per two cycles with zero-wait ROM. This is accepted for this revision.
- Redirect in any non-reset state:
  - PC<=iBranch_dir, oInstruction<=NOP_INSTR, oInstr_valid<=0, state<=S_FETCH.
  - If iMem_ready=1 in the same cycle, the returned data is discarded and PC is not incremented.
  - Next cycle: oMem_req=1 with oMem_addr=iBranch_dir.
- Redirect latency: target appears on oMem_addr exactly 1 cycle after redirect is sampled.
- Redirect held high for 2+ consecutive cycles: each cycle reloads PC from iBranch_dir; the last value wins.
- Redirect while in S_HOLD with iStall=1: the held instruction is squashed anyway.
- oMem_addr is always driven with PC, even when oMem_req=0.

Decomposition:
- Shared package/defines file (same file that holds the opcode constants):
  - ADDR_W, INSTR_W, NOP_INSTR
  - FSM state encoding: S_RESET=2'd0, S_FETCH=2'd1, S_HOLD=2'd2
- Optional sub-module pc_reg: PC register with load/increment/reset and wrap. It stays under the same Clock/Reset.

Test Plan:
- Reset then zero-wait ROM returning addr+16'h1000: oInstruction sequence 16'h1000, 16'h1001, 16'h1002, with valid on every 2nd cycle and oPC 0,1,2.
- ROM ready delayed 3 cycles at PC=5: oMem_addr stays 10'd5 and oMem_req=1 for 3 cycles, then oInstruction=16'h1005 with valid=1 one cycle after ready.
- iJumpTaken=1 with iBranch_dir=10'd300 while ROM ready is high on PC=7: data for addr 7 discarded, oInstr_valid=0, next cycle oMem_addr=300.
- PC=1023 fetch completes: next oMem_addr=0, oPC=1023 on the issued instruction.
- iStall=1 for 4 cycles in S_HOLD: oInstruction/oPC stable, oMem_req=0; then iBranch_taken=1 with dir 10'd64 during the stall: NOP issued and next request to 64.
- Reset asserted mid-fetch while iMem_ready=1: outputs at reset values next cycle, oMem_req=0 for at least 1 cycle, then fetch from RESET_PC.
